// File: rtl/uart_rx_deser.sv
// 16x-oversampled 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// byte presented on a valid/ready register with overrun and framing-error pulses.
module uart_rx_deser #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk50m,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic          rxd_m, rxd_s;
  logic [CW-1:0] div_cnt;
  logic          tick;
  state_t        state, state_nxt;
  logic [3:0]    samp, samp_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [1:0]    votes, votes_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          done, done_nxt;
  logic          ferr_nxt;
  logic          maj;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      div_cnt <= '0;
    end else begin
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == CW'(DIV - 1));
  // votes hold the s=7 and s=8 samples; the s=9 sample is taken live
  assign maj  = (votes[0] & votes[1]) | (votes[0] & rxd_s) | (votes[1] & rxd_s);

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      samp      <= 4'd0;
      bit_cnt   <= 3'd0;
      votes     <= 2'b00;
      shreg     <= 8'h00;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      samp      <= samp_nxt;
      bit_cnt   <= bit_nxt;
      votes     <= votes_nxt;
      shreg     <= shreg_nxt;
      done      <= done_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // samp holds the index the next tick will carry in the current state
  always_comb begin
    state_nxt = state;
    samp_nxt  = samp;
    bit_nxt   = bit_cnt;
    votes_nxt = votes;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    if (tick) begin
      samp_nxt = samp + 4'd1;
      if (samp == 4'd7) votes_nxt[0] = rxd_s;
      if (samp == 4'd8) votes_nxt[1] = rxd_s;
      case (state)
        IDLE: begin
          samp_nxt = 4'd0;
          if (!rxd_s) begin
            state_nxt = START;
            samp_nxt  = 4'd1;
          end
        end
        START: begin
          if (samp == 4'd9 && maj) begin
            state_nxt = IDLE;
            samp_nxt  = 4'd0;
          end else if (samp == 4'd15) begin
            state_nxt = DATA;
            bit_nxt   = 3'd0;
          end
        end
        DATA: begin
          if (samp == 4'd9) shreg_nxt = {maj, shreg[7:1]};
          if (samp == 4'd15) begin
            if (bit_cnt == 3'd7) state_nxt = STOP;
            else                 bit_nxt   = bit_cnt + 3'd1;
          end
        end
        STOP: begin
          // leave at mid-stop so the next start edge is caught with margin
          if (samp == 4'd9) begin
            samp_nxt = 4'd0;
            if (maj) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          samp_nxt = 4'd0;
          if (rxd_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser, run at a scaled baud rate (DIV=4, 64 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_deser;

  localparam int BT   = 1280;  // 16 ticks * 4 clocks * 20 ns
  localparam int BT_F = 1256;  // about 1.9% fast

  logic       clk50m;
  logic       reset_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  int         hs_cnt   = 0;
  int         vcyc_cnt = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  logic [7:0] got_mem [0:255];

  int hs0, vc0, fe0, ov0;

  uart_rx_deser #(.CLK_FREQ(50000000), .BAUD(781250), .OVERSAMPLE(16)) dut (
    .clk50m   (clk50m),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial begin
    clk50m = 1'b0;
    #5;
    forever #10 clk50m = ~clk50m;
  end

  always @(negedge clk50m) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        got_mem[hs_cnt[7:0]] = rx_data;
        hs_cnt = hs_cnt + 1;
      end
      if (rx_valid)  vcyc_cnt = vcyc_cnt + 1;
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (overrun)   ovr_cnt  = ovr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // start, 8 data bits LSB first, stop; the line is left at the stop level
  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_val);
    rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bt);
    end
    rxd = stop_val;
    #(bt);
  endtask

  task automatic snap();
    hs0 = hs_cnt;
    vc0 = vcyc_cnt;
    fe0 = ferr_cnt;
    ov0 = ovr_cnt;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk50m);
    #1 rx_ready = v;
  endtask

  initial begin
    reset_n  = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    #100;
    chk("rst_data",  32'(rx_data),   32'h00);
    chk("rst_valid", 32'(rx_valid),  32'h0);
    chk("rst_ferr",  32'(frame_err), 32'h0);
    chk("rst_ovr",   32'(overrun),   32'h0);
    @(negedge clk50m);
    reset_n = 1'b1;
    #(2*BT);

    // single byte at nominal rate
    snap();
    send_frame(8'h48, BT, 1'b1);
    #(2*BT);
    chk("t1_hs",    32'(hs_cnt - hs0),   32'd1);
    chk("t1_data",  32'(got_mem[hs0[7:0]]), 32'h48);
    chk("t1_vcyc",  32'(vcyc_cnt - vc0), 32'd1);
    chk("t1_ferr",  32'(ferr_cnt - fe0), 32'd0);
    chk("t1_ovr",   32'(ovr_cnt - ov0),  32'd0);

    // back-to-back frames from a fast transmitter
    snap();
    send_frame(8'h48, BT_F, 1'b1);
    send_frame(8'h49, BT_F, 1'b1);
    send_frame(8'h20, BT_F, 1'b1);
    rxd = 1'b1;
    #(2*BT);
    chk("t2_hs",    32'(hs_cnt - hs0), 32'd3);
    chk("t2_d0",    32'(got_mem[8'(hs0)]),     32'h48);
    chk("t2_d1",    32'(got_mem[8'(hs0 + 1)]), 32'h49);
    chk("t2_d2",    32'(got_mem[8'(hs0 + 2)]), 32'h20);
    chk("t2_ferr",  32'(ferr_cnt - fe0), 32'd0);

    // short low glitch is rejected as a false start
    snap();
    rxd = 1'b0;
    #300;
    rxd = 1'b1;
    #(2*BT);
    chk("t3_hs",   32'(hs_cnt - hs0),   32'd0);
    chk("t3_vcyc", 32'(vcyc_cnt - vc0), 32'd0);
    chk("t3_ferr", 32'(ferr_cnt - fe0), 32'd0);

    // stop bit low followed by a break, then a clean frame
    snap();
    send_frame(8'h55, BT, 1'b0);
    #(3*BT);
    rxd = 1'b1;
    #(2*BT);
    chk("t4_ferr", 32'(ferr_cnt - fe0), 32'd1);
    chk("t4_hs",   32'(hs_cnt - hs0),   32'd0);
    snap();
    send_frame(8'h41, BT, 1'b1);
    #(2*BT);
    chk("t4_hs2",   32'(hs_cnt - hs0), 32'd1);
    chk("t4_data2", 32'(got_mem[hs0[7:0]]), 32'h41);
    chk("t4_ferr2", 32'(ferr_cnt - fe0), 32'd0);

    // consumer stalled: second byte is dropped with an overrun pulse
    set_ready(1'b0);
    snap();
    send_frame(8'h48, BT, 1'b1);
    #(2*BT);
    send_frame(8'h49, BT, 1'b1);
    #(2*BT);
    chk("t5_valid", 32'(rx_valid), 32'h1);
    chk("t5_data",  32'(rx_data),  32'h48);
    chk("t5_ovr",   32'(ovr_cnt - ov0),  32'd1);
    chk("t5_ferr",  32'(ferr_cnt - fe0), 32'd0);
    chk("t5_hs0",   32'(hs_cnt - hs0),   32'd0);
    set_ready(1'b1);
    repeat (4) @(posedge clk50m);
    #1;
    chk("t5_hs1",    32'(hs_cnt - hs0), 32'd1);
    chk("t5_acc",    32'(got_mem[hs0[7:0]]), 32'h48);
    chk("t5_vdrop",  32'(rx_valid), 32'h0);

    // hold a byte, then reset during bit 4 of the next frame
    set_ready(1'b0);
    send_frame(8'h5A, BT, 1'b1);
    #(2*BT);
    chk("t6_pre_valid", 32'(rx_valid), 32'h1);
    chk("t6_pre_data",  32'(rx_data),  32'h5A);
    begin
      logic [7:0] b;
      b = 8'h48;
      rxd = 1'b0;
      #(BT);
      for (int i = 0; i < 4; i++) begin
        rxd = b[i];
        #(BT);
      end
      rxd = b[4];
      #(BT/2);
    end
    reset_n = 1'b0;
    rxd     = 1'b1;
    #100;
    chk("t6_rst_valid", 32'(rx_valid),  32'h0);
    chk("t6_rst_data",  32'(rx_data),   32'h00);
    chk("t6_rst_ferr",  32'(frame_err), 32'h0);
    chk("t6_rst_ovr",   32'(overrun),   32'h0);
    @(negedge clk50m);
    reset_n = 1'b1;
    set_ready(1'b1);
    snap();
    #(12*BT);
    chk("t6_nobyte", 32'(hs_cnt - hs0),   32'd0);
    chk("t6_noferr", 32'(ferr_cnt - fe0), 32'd0);
    snap();
    send_frame(8'h49, BT, 1'b1);
    #(2*BT);
    chk("t6_hs",   32'(hs_cnt - hs0), 32'd1);
    chk("t6_data", 32'(got_mem[hs0[7:0]]), 32'h49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
